// File: rtl/clock_time_setter.sv
`default_nettype none
// ============================================================================
// clock_time_setter : snapshot/edit/commit front end for the 24h BCD clock.
// Optional inactivity timeout: CLOCK_SETTER_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module clock_time_setter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [23:0] Time_out,
  input  logic        Edit_btn,
  input  logic        Inc_btn,
  input  logic        Dec_btn,
  input  logic        Cancel_btn,
  output logic [23:0] Time_in,
  output logic        Set_time,
  output logic        Editing,
  output logic [1:0]  Field_sel
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HH     = 3'd1;
  localparam logic [2:0] S_MM     = 3'd2;
  localparam logic [2:0] S_SS     = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [23:0] buf_q, buf_d;
  logic [3:0]  prev_q;
  logic        armed_q;
  logic [3:0]  w_btn, w_edges;
  logic        w_in_edit, w_timeout;
  logic        e_cancel, e_edit, e_inc, e_dec;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic [7:0] bcd_step(input logic [7:0] f, input logic [7:0] maxv,
                                          input logic up);
    logic [3:0] t, u;
    t = f[7:4];
    u = f[3:0];
    // With both digits valid, packed BCD compares like the decimal value.
    if (t > 4'd9 || u > 4'd9 || f > maxv) bcd_step = 8'h00;
    else if (up) begin
      if (f == maxv)      bcd_step = 8'h00;
      else if (u == 4'd9) bcd_step = {t + 4'd1, 4'd0};
      else                bcd_step = {t, u + 4'd1};
    end else begin
      if (f == 8'h00)     bcd_step = maxv;
      else if (u == 4'd0) bcd_step = {t - 4'd1, 4'd9};
      else                bcd_step = {t, u - 4'd1};
    end
  endfunction

  // The first clock after reset only loads the history, so a button held
  // across reset release must fall and rise again to act.
  assign w_btn     = {Cancel_btn, Edit_btn, Inc_btn, Dec_btn};
  assign w_edges   = armed_q ? (w_btn & ~prev_q) : 4'b0000;
  assign e_cancel  = w_edges[3];
  assign e_edit    = w_edges[2];
  assign e_inc     = w_edges[1];
  assign e_dec     = w_edges[0];
  assign w_in_edit = (state_q == S_HH) || (state_q == S_MM) || (state_q == S_SS);

`ifdef CLOCK_SETTER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign w_timeout = w_in_edit && (w_edges == 4'b0000) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!w_in_edit || (w_edges != 4'b0000) || w_timeout) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      buf_q   <= 24'h000000;
      prev_q  <= 4'b0000;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      prev_q  <= w_btn;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (e_edit) begin
          buf_d   = Time_out;
          state_d = S_HH;
        end
      end
      S_HH, S_MM, S_SS: begin
        if (e_cancel)       state_d = S_IDLE;
        else if (e_edit)    state_d = (state_q == S_SS) ? S_COMMIT : state_q + 3'd1;
        else if (e_inc ^ e_dec) begin
          case (state_q)
            S_HH:    buf_d[23:16] = bcd_step(buf_q[23:16], 8'h23, e_inc);
            S_MM:    buf_d[15:8]  = bcd_step(buf_q[15:8],  8'h59, e_inc);
            default: buf_d[7:0]   = bcd_step(buf_q[7:0],   8'h59, e_inc);
          endcase
        end
        else if (w_timeout) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Time_in   = buf_q;
    Set_time  = (state_q == S_COMMIT);
    Editing   = w_in_edit;
    Field_sel = w_in_edit ? state_q[1:0] : 2'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_time_setter.sv
`default_nettype none
// ============================================================================
// tb_clock_time_setter : scoreboard bench with a decimal-arithmetic model.
// Rev 1.0
// ============================================================================
module tb_clock_time_setter;
  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] time_out = 24'h0;
  logic        b_edit = 1'b0, b_inc = 1'b0, b_dec = 1'b0, b_cancel = 1'b0;
  logic [23:0] time_in;
  logic        set_time, editing;
  logic [1:0]  field_sel;

  clock_time_setter #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(clk), .Reset_n(rst_n), .Time_out(time_out),
    .Edit_btn(b_edit), .Inc_btn(b_inc), .Dec_btn(b_dec), .Cancel_btn(b_cancel),
    .Time_in(time_in), .Set_time(set_time), .Editing(editing), .Field_sel(field_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] t;
    logic        s;
    logic        e;
    logic [1:0]  f;
  } out_t;

  out_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1..3 editing HH/MM/SS, 4 commit.
  int          m_mode = 0;
  logic [23:0] m_buf = 24'h0;
  logic [3:0]  m_prev = 4'b0;
  bit          m_armed = 1'b0;
  int          m_cnt = 0;
  logic [23:0] cur_to = 24'h0;

  function automatic logic [7:0] fstep(input logic [7:0] b, input int maxv, input bit up);
    int t, u, v;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9 || t * 10 + u > maxv) return 8'h00;
    v = t * 10 + u;
    if (up) v = (v == maxv) ? 0 : v + 1;
    else    v = (v == 0) ? maxv : v - 1;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input bit r, input logic [23:0] to,
                            input bit e, input bit i, input bit d, input bit c);
    logic [3:0] lv, ed;
    bit timeout_en;
    out_t o;
    timeout_en = 1'b0;
`ifdef CLOCK_SETTER_TIMEOUT_EN
    timeout_en = 1'b1;
`endif
    if (!r) begin
      m_mode = 0; m_buf = 24'h0; m_prev = 4'b0; m_armed = 1'b0; m_cnt = 0;
    end else begin
      lv = {c, e, i, d};
      ed = m_armed ? (lv & ~m_prev) : 4'b0;
      m_prev = lv;
      m_armed = 1'b1;
      if (m_mode == 0) begin
        if (ed[2]) begin m_buf = to; m_mode = 1; end
      end else if (m_mode == 4) begin
        m_mode = 0;
      end else begin
        if (ed[3]) m_mode = 0;
        else if (ed[2]) m_mode = m_mode + 1;
        else if (ed[1] != ed[0]) begin
          if (m_mode == 1)      m_buf[23:16] = fstep(m_buf[23:16], 23, ed[1]);
          else if (m_mode == 2) m_buf[15:8]  = fstep(m_buf[15:8],  59, ed[1]);
          else                  m_buf[7:0]   = fstep(m_buf[7:0],   59, ed[1]);
        end
        else if (timeout_en && m_cnt == int'(T) - 1) m_mode = 0;
      end
      if (m_mode < 1 || m_mode > 3 || ed != 4'b0) m_cnt = 0;
      else m_cnt = m_cnt + 1;
    end
    o.t = m_buf;
    o.s = (m_mode == 4);
    o.e = (m_mode >= 1 && m_mode <= 3);
    o.f = o.e ? 2'(m_mode) : 2'd0;
    exp_q.push_back(o);
  endtask

  task automatic cycle(input bit r, input logic [23:0] to,
                       input bit e, input bit i, input bit d, input bit c);
    @(negedge clk);
    rst_n = r; time_out = to; b_edit = e; b_inc = i; b_dec = d; b_cancel = c;
    model_step(r, to, e, i, d, c);
    if (!r) begin
      #1;
      n_cmp++;
      if (set_time !== 1'b0 || editing !== 1'b0 || field_sel !== 2'd0 || time_in !== 24'h0) begin
        n_bad++;
        $display("FAIL async_reset got t=%h s=%b e=%b f=%0d required t=000000 s=0 e=0 f=0",
                 time_in, set_time, editing, field_sel);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1, cur_to, 0, 0, 0, 0);
  endtask

  task automatic press(input bit e, input bit i, input bit d, input bit c);
    cycle(1, cur_to, e, i, d, c);
    cycle(1, cur_to, 0, 0, 0, 0);
  endtask

  task automatic start_edit(input logic [23:0] to);
    cur_to = to;
    press(1, 0, 0, 0);
  endtask

  // Monitor: outputs are Moore, so every cycle presents a result.
  initial begin
    out_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_cmp++;
        if (time_in !== x.t || set_time !== x.s || editing !== x.e || field_sel !== x.f) begin
          n_bad++;
          $display("FAIL outputs @%0t got t=%h s=%b e=%b f=%0d required t=%h s=%b e=%b f=%0d",
                   $time, time_in, set_time, editing, field_sel, x.t, x.s, x.e, x.f);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) cycle(0, 24'h0, 0, 0, 0, 0);
    idle(6);

    start_edit(24'h124530);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    idle(3);

    start_edit(24'h235959);
    press(0, 1, 0, 0); press(1, 0, 0, 0);
    press(0, 1, 0, 0); press(1, 0, 0, 0);
    press(0, 1, 0, 0); press(1, 0, 0, 0);
    idle(2);

    start_edit(24'h000000);
    press(0, 0, 1, 0); press(1, 0, 0, 0);
    press(0, 0, 1, 0); press(1, 0, 0, 0);
    press(0, 0, 1, 0); press(1, 0, 0, 0);
    idle(2);

    start_edit(24'h091000);
    press(0, 1, 0, 0); press(1, 0, 0, 0);
    press(0, 0, 1, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    idle(2);

    start_edit(24'h3A0000);
    press(0, 1, 0, 0); press(0, 0, 0, 1);

    start_edit(24'h101010);
    press(0, 1, 0, 0); press(0, 0, 0, 1); idle(2);

    start_edit(24'h111111);
    press(1, 0, 0, 1); idle(2);

    start_edit(24'h151515);
    press(0, 1, 1, 0); press(0, 0, 0, 1);

    start_edit(24'h050505);
    for (int k = 0; k < 20; k++) cycle(1, cur_to, 0, 1, 0, 0);
    idle(1); press(0, 0, 0, 1);

    start_edit(24'h202020);
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    cycle(0, cur_to, 0, 0, 0, 0); cycle(0, cur_to, 0, 0, 0, 0);
    idle(3);

    cycle(0, cur_to, 1, 0, 0, 0); cycle(0, cur_to, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, cur_to, 1, 0, 0, 0);
    idle(2);
    press(1, 0, 0, 0); press(0, 0, 0, 1);

    start_edit(24'h010203);
    idle(20);
    press(0, 0, 0, 1);

    start_edit(24'h010203);
    for (int k = 0; k < 6; k++) begin
      cycle(1, cur_to, 0, 1, 0, 0);
      idle(9);
    end
    press(0, 0, 0, 1);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) cur_to = $urandom;
      else if ($urandom_range(0, 7) == 0)
        cur_to = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      cycle(($urandom_range(0, 149) != 0), cur_to,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    idle(2);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
